// File: rtl/core_control.sv
// 8085-style bus/timing controller: one-hot T-state sequencer for opcode fetch plus up to four extra machine cycles.
// Control pins and output enables are decoded from the current T-state and the latched instruction.
module core_control #(
  parameter int INSTSIZE   = 17,
  parameter int INST_GO6   = 0,
  parameter int INST_DAD   = 1,
  parameter int INST_HLT   = 2,
  parameter int INST_DIO   = 3,
  parameter int INST_CYL   = 4,
  parameter int INST_CYH   = 7,
  parameter int INST_RWL   = 8,
  parameter int INST_RWH   = 11,
  parameter int INST_CDL   = 12,
  parameter int INST_CDH   = 15,
  parameter int INST_CCC   = 16,
  parameter int IPIN_READY = 0,
  parameter int IPIN_HOLD  = 1,
  parameter int IPIN_COND  = 2,
  parameter int IPIN_COUNT = 3,
  parameter int OENB_COUNT = 3,
  parameter int OPIN_COUNT = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INSTSIZE-1:0]   inst,
  input  logic [IPIN_COUNT-1:0] ipin,
  output logic [OENB_COUNT-1:0] oenb,
  output logic [OPIN_COUNT-1:0] opin
);

  typedef enum logic [9:0] {
    S_TR    = 10'b00_0000_0001,
    S_T1    = 10'b00_0000_0010,
    S_T2    = 10'b00_0000_0100,
    S_T3    = 10'b00_0000_1000,
    S_T4    = 10'b00_0001_0000,
    S_T5    = 10'b00_0010_0000,
    S_T6    = 10'b00_0100_0000,
    S_TW    = 10'b00_1000_0000,
    S_TH    = 10'b01_0000_0000,
    S_THOLD = 10'b10_0000_0000
  } state_t;

  state_t cstate, nstate, done_state;

  logic [INSTSIZE-1:1] ireg;
  logic [2:0] mcyc, mcyc_nxt;   // 0 = opcode fetch, 1..4 = M2..M5
  logic [1:0] idx;
  logic [3:0] cy_en, rem_mask, rem, rw, cd;
  logic       hold_req, halted;
  logic       ready, hold, cond;
  logic       is_m1, cur_hlt, cur_ccc, skip, end_cyc, go_halt;
  logic       bus, active, c_dad, c_wr, c_rd, c_iom;
  logic       dofirst, do_last;
  logic       ale, rd_n, wr_n, iom, s0, s1, hlda;

  assign ready = ipin[IPIN_READY];
  assign hold  = ipin[IPIN_HOLD];
  assign cond  = ipin[IPIN_COND];

  // The instruction is live on the inputs during T4 and only the latched copy is trusted afterwards.
  assign cy_en   = (cstate == S_T4) ? inst[INST_CYH:INST_CYL] : ireg[INST_CYH:INST_CYL];
  assign cur_hlt = (cstate == S_T4) ? inst[INST_HLT] : ireg[INST_HLT];
  assign cur_ccc = (cstate == S_T4) ? inst[INST_CCC] : ireg[INST_CCC];
  assign rw      = ireg[INST_RWH:INST_RWL];
  assign cd      = ireg[INST_CDH:INST_CDL];

  assign is_m1    = (mcyc == 3'd0);
  assign idx      = mcyc[1:0] - 2'd1;
  assign rem_mask = is_m1 ? 4'b1111 : (4'b1110 << idx);
  assign rem      = cy_en & rem_mask;
  assign skip     = is_m1 && cur_ccc && !cond;
  assign dofirst  = (rem == 4'b0000) || skip;

  always_comb begin
    mcyc_nxt = 3'd0;
    if (!dofirst) begin
      for (int i = 3; i >= 0; i--) begin
        if (rem[i]) mcyc_nxt = 3'(i + 1);
      end
    end
  end

  assign bus     = (cstate == S_T2) || (cstate == S_TW) || (cstate == S_T3);
  assign active  = bus || (cstate == S_T1) || (cstate == S_T4) || (cstate == S_T5) || (cstate == S_T6);
  assign do_last = !is_m1 && (rem == 4'b0000) && (bus || (cstate == S_T1));

  assign c_dad = !is_m1 && ireg[INST_DAD];
  assign c_wr  = !is_m1 && !c_dad && rw[idx];
  assign c_rd  = !is_m1 && !c_dad && !rw[idx];
  assign c_iom = !is_m1 && cd[idx] && ireg[INST_DIO];

  assign go_halt    = is_m1 && cur_hlt;
  assign end_cyc    = ((cstate == S_T3) && !is_m1) || ((cstate == S_T4) && !inst[INST_GO6]) || (cstate == S_T6);
  assign done_state = hold_req ? S_THOLD : (go_halt ? S_TH : S_T1);

  always_comb begin
    nstate = cstate;
    unique case (cstate)
      S_TR:    nstate = S_T1;
      S_T1:    nstate = S_T2;
      S_T2:    nstate = ready ? S_T3 : S_TW;
      S_TW:    nstate = ready ? S_T3 : S_TW;
      S_T3:    nstate = is_m1 ? S_T4 : done_state;
      S_T4:    nstate = inst[INST_GO6] ? S_T5 : done_state;
      S_T5:    nstate = S_T6;
      S_T6:    nstate = done_state;
      S_TH:    nstate = hold ? S_THOLD : S_TH;
      S_THOLD: nstate = hold ? S_THOLD : (halted ? S_TH : S_T1);
      default: nstate = S_TR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cstate   <= S_TR;
      ireg     <= '0;
      mcyc     <= 3'd0;
      hold_req <= 1'b0;
      halted   <= 1'b0;
    end else begin
      cstate <= nstate;
      if (cstate == S_T4) ireg <= inst[INSTSIZE-1:1];
      if (cstate == S_T2 && hold) hold_req <= 1'b1;
      else if (cstate == S_THOLD) hold_req <= 1'b0;
      if (end_cyc) begin
        mcyc   <= go_halt ? 3'd0 : mcyc_nxt;
        halted <= go_halt;
      end
    end
  end

  // Idle-cycle (DAD) extras report as reads on S1/S0 but never strobe the bus.
  always_comb begin
    ale  = 1'b0;
    rd_n = 1'b1;
    wr_n = 1'b1;
    iom  = 1'b0;
    s0   = 1'b0;
    s1   = 1'b0;
    hlda = 1'b0;
    oenb = 3'b000;
    if (active || cstate == S_TW) begin
      ale  = (cstate == S_T1) && !c_dad;
      rd_n = !(bus && (is_m1 || c_rd));
      wr_n = !(bus && c_wr);
      iom  = c_iom;
      s1   = is_m1 || !c_wr;
      s0   = is_m1 || c_wr;
      oenb = {1'b1, (cstate == S_T1) || (bus && c_wr), (cstate == S_T1) || bus};
    end else if (cstate == S_TH) begin
      oenb = 3'b100;
    end else if (cstate == S_THOLD) begin
      hlda = 1'b1;
    end
  end

  assign opin = {hlda, s1, s0, iom, wr_n, rd_n, ale};

endmodule

// File: tb/tb_core_control.sv
// Randomized bench for core_control: builds the expected T-state/pin trace per instruction from machine-cycle rules.
module tb_core_control;

  localparam int TR = 0, T1 = 1, T2 = 2, T3 = 3, T4 = 4, T5 = 5, T6 = 6, TW = 7, TH = 8, THOLD = 9;
  localparam int K_FETCH = 0, K_RD = 1, K_WR = 2, K_IDLE = 3;

  typedef struct {
    int          st;
    logic [6:0]  op;
    logic [6:0]  opm;
    logic [2:0]  oe;
    logic        dl;
    logic        rdy;
    logic        hld;
    logic        cnd;
    logic        ival;
    logic        cf;
    logic        df;
    logic [16:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [16:0] cur_plan;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] inst;
  logic [2:0]  ipin;
  logic [2:0]  oenb;
  logic [6:0]  opin;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  core_control dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst),
    .ipin (ipin),
    .oenb (oenb),
    .opin (opin)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected pins for one T-state of a machine cycle of the given kind.
  function automatic ent_t mk(input int st, input int kind, input logic iom, input logic dl);
    ent_t e;
    logic bus, ale, rdn, wrn, s1, s0;
    e.st = st; e.dl = dl; e.opm = 7'h7f; e.rdy = 1'($urandom); e.hld = 1'b0;
    e.cnd = 1'($urandom); e.ival = 1'b0; e.cf = 1'b0; e.df = 1'b0; e.ins = cur_plan;
    if (st == TH) begin
      e.op = 7'b0000110; e.oe = 3'b100;
    end else if (st == THOLD) begin
      e.op = 7'b1000000; e.opm = 7'b1000000; e.oe = 3'b000;
    end else begin
      bus = (st == T2) || (st == T3) || (st == TW);
      ale = (st == T1) && (kind != K_IDLE);
      rdn = !(bus && (kind == K_FETCH || kind == K_RD));
      wrn = !(bus && kind == K_WR);
      s1  = (kind != K_WR);
      s0  = (kind == K_FETCH) || (kind == K_WR);
      e.op = {1'b0, s1, s0, iom, wrn, rdn, ale};
      e.oe = {1'b1, (st == T1) || (bus && kind == K_WR), (st == T1) || bus};
    end
    return e;
  endfunction

  task automatic add_bus(input int kind, input logic iom, input logic dl, input logic m1, input logic hreq);
    int   w;
    ent_t e;
    w = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
    q.push_back(mk(T1, kind, iom, dl));
    e = mk(T2, kind, iom, dl); e.rdy = (w == 0); e.hld = hreq; e.ival = m1; q.push_back(e);
    for (int i = 0; i < w; i++) begin
      e = mk(TW, kind, iom, dl); e.rdy = (i == w - 1); e.ival = m1; q.push_back(e);
    end
    e = mk(T3, kind, iom, dl); e.ival = m1; q.push_back(e);
  endtask

  task automatic add_hold(input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e = mk(THOLD, K_IDLE, 1'b0, 1'b0); e.hld = (i < n - 1); q.push_back(e);
    end
  endtask

  task automatic plan(input logic [16:0] ins, input logic rnd_hold);
    int         hold_at, j, kind;
    int         ex[$];
    ent_t       e;
    logic [3:0] cy;
    cur_plan = ins;
    hold_at = (rnd_hold && $urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
    add_bus(K_FETCH, 1'b0, 1'b0, 1'b1, hold_at == 0);
    e = mk(T4, K_FETCH, 1'b0, 1'b0); e.ival = 1'b1; q.push_back(e);
    if (ins[0]) begin
      q.push_back(mk(T5, K_FETCH, 1'b0, 1'b0));
      q.push_back(mk(T6, K_FETCH, 1'b0, 1'b0));
    end
    e = q.pop_back();
    cy = ins[7:4];
    if (!ins[2] && !(ins[16] && !e.cnd)) begin
      for (int k = 0; k < 4; k++) if (cy[k]) ex.push_back(k);
    end
    e.cf = !ins[2];
    e.df = (ex.size() == 0);
    q.push_back(e);
    if (ins[2]) return;
    if (hold_at == 0) add_hold($urandom_range(1, 3));
    for (int k = 0; k < ex.size(); k++) begin
      j = ex[k];
      kind = ins[1] ? K_IDLE : (ins[8 + j] ? K_WR : K_RD);
      add_bus(kind, ins[12 + j] & ins[3], k == ex.size() - 1, 1'b0, hold_at == k + 1);
      if (hold_at == k + 1) add_hold($urandom_range(1, 3));
    end
  endtask

  initial begin
    logic [16:0] dir[8];
    ent_t        e;
    dir = '{17'h00000, 17'h00001, 17'h00010, 17'h00110, 17'h04070, 17'h04470, 17'h00032, 17'h11018};

    for (int i = 0; i < 8; i++) plan(dir[i], 1'b0);
    for (int i = 0; i < 150; i++) plan(17'($urandom) & ~17'h00004, 1'b1);
    plan(17'h00004, 1'b0);
    cur_plan = 17'h00004;
    for (int i = 0; i < 3; i++) q.push_back(mk(TH, K_IDLE, 1'b0, 1'b0));
    e = mk(TH, K_IDLE, 1'b0, 1'b0); e.hld = 1'b1; q.push_back(e);
    add_hold(2);
    for (int i = 0; i < 3; i++) q.push_back(mk(TH, K_IDLE, 1'b0, 1'b0));

    rst = 1'b1; inst = '0; ipin = '0;
    repeat (2) @(negedge clk);
    check("reset_cstate", 32'(dut.cstate), 32'h1);
    check("reset_opin", 32'(opin), 32'h06);
    check("reset_oenb", 32'(oenb), 32'h0);
    rst = 1'b0;

    foreach (q[i]) begin
      @(negedge clk);
      inst = q[i].ival ? q[i].ins : 17'($urandom);
      ipin = {q[i].cnd, q[i].hld, q[i].rdy};
      #1;
      check("cstate", 32'(dut.cstate), 32'(1) << q[i].st);
      check("opin", 32'(opin & q[i].opm), 32'(q[i].op & q[i].opm));
      check("oenb", 32'(oenb), 32'(q[i].oe));
      check("do_last", 32'(dut.do_last), 32'(q[i].dl));
      if (q[i].cf) check("dofirst", 32'(dut.dofirst), 32'(q[i].df));
    end

    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cstate", 32'(dut.cstate), 32'h1);
    check("async_rst_opin", 32'(opin), 32'h06);
    check("async_rst_oenb", 32'(oenb), 32'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/core_control.md
Name: core_control

Overview:
- 8085-style CPU bus/timing controller: one-hot T-state sequencer that runs the opcode fetch and up to four further machine cycles per instruction, from a decoded instruction word.
- Drives the external control pins (ALE, RD_, WR_, IO/M, S1/S0, HLDA) and bus output enables; samples READY, HOLD and a condition flag.
- Sits between the decoder and the pin/bus drivers of the core.

Parameters:
INSTSIZE, 17, decoded instruction word width
INST_GO6, 0, opcode fetch lasts 6 states (T1-T6) instead of 4
INST_DAD, 1, extra machine cycles are bus-idle (no ALE/RD_/WR_)
INST_HLT, 2, halt after opcode fetch
INST_DIO, 3, data cycles are I/O cycles (IO/M=1)
INST_CYL/INST_CYH, 4/7, enable of machine cycles M2..M5 (bit CYL+i = M(i+2))
INST_RWL/INST_RWH, 8/11, per-cycle direction: 1=write, 0=read
INST_CDL/INST_CDH, 12/15, per-cycle address kind: 1=data, 0=code/operand
INST_CCC, 16, conditional instruction
IPIN_READY, 0, ready input index
IPIN_HOLD, 1, hold request index
IPIN_COND, 2, condition-true input index
IPIN_COUNT, 3, ipin width
OENB_COUNT, 3, oenb width: bit0 A15-A8, bit1 AD7-AD0, bit2 control pins
OPIN_COUNT, 7, opin width: bit0 ALE, bit1 RD_, bit2 WR_, bit3 IO/M, bit4 S0, bit5 S1, bit6 HLDA

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
inst  input  INSTSIZE  decoded instruction; valid from T2 of opcode fetch
ipin  input  IPIN_COUNT  READY/HOLD/COND
oenb  output  OENB_COUNT  active-high output enables
opin  output  OPIN_COUNT  control pin levels

Behaviour:
- Internal one-hot state register, exactly this name and encoding: cstate[9:0] — bit0 TR (reset), bits1-6 T1-T6, bit7 TW, bit8 TH (halt), bit9 THOLD. Exactly one bit is high.
- Required internal signals (benches probe them):
  - dofirst: combinational; 1 when the next T1 starts an opcode fetch (no further machine cycles remain).
  - do_last: 1 throughout the last extra machine cycle of a multi-cycle instruction.
- Reset: cstate=TR; opin=ALE0 RD_1 WR_1 IOM0 S0 0 S1 0 HLDA0; oenb=000. First clock after release -> T1 of opcode fetch (M1).
- Opcode fetch M1: T1 -> T2 -> T3 -> T4, then T5 -> T6 if inst[INST_GO6].
  - T2: if READY=0 go to TW; stay in TW while READY=0; then T3.
  - inst sampled at T4; held internally until instruction end.
- After T4/T6:
  - HLT -> TH.
  - CCC with COND=0 -> next M1.
  - Otherwise run each enabled cycle M2..M5 in ascending order, each T1 -> T2 (TW while not READY) -> T3; no enabled cycle -> next M1.
  - After the last enabled cycle's T3 -> next M1.
- Pins:
  - ALE=1 in T1 only.
  - RD_=0 in T2/TW/T3 of read cycles and M1.
  - WR_=0 in T2/TW/T3 of write cycles.
  - S1S0: fetch=11, read=10, write=01, halt=00.
  - IO/M=1 only in cycles with CD=1 when DIO=1.
- DAD: extra cycles keep ALE=0, RD_=WR_=1; S1S0=10.
- Enables:
  - oenb[0]=1 in T1-T3/TW.
  - oenb[1]=1 in T1, and in T2/TW/T3 of write cycles.
  - oenb[2]=1 except in THOLD.
  - T4-T6: oenb[1]=0, RD_=WR_=1.
- HOLD: sampled in T2. If high, after the current machine cycle ends enter THOLD (HLDA=1, oenb=000). Leave one clock after HOLD=0, into the T1 the sequencer would otherwise have taken.
- TH: ALE=0, RD_=WR_=1, oenb[1:0]=00. Exits only by reset or HOLD (THOLD then back to TH).
- Asynchronous reset at any state returns immediately to TR with reset outputs.

Test Plan:
- inst=0 given at T2 -> T1,T2,T3,T4 then T1; dofirst=1 at T4; ALE only in T1; S1S0=11.
- inst=GO6 only -> T1..T6 then T1.
- inst CY bit4=1 (FR) -> M1 (4 states) then read cycle T1-T3 with RD_=0, S1S0=10; do_last=1 during it; then M1.
- inst CY bit4=1, RW bit8=1 (FW) -> second cycle WR_=0, S1S0=01, oenb[1]=1 in T2-T3.
- inst CY=0111, CD=0100 (lda) -> M1 + three read cycles; do_last only in M4. inst CY=0111, RW=0100, CD=0100 (sta) -> M4 is a write.
- READY=0 during T2 for 2 clocks -> two TW states then T3. HLT=1 -> TH held until rst.
